// File: rtl/mdio_master.sv
// Clause 22 MDIO management initiator: serialises one read/write frame per command on MDC/MDIO.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN adds cmd_nopre to skip the 32-bit preamble per command.
module mdio_master #(
  parameter int CLK_DIV       = 4,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_nopre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]      PRE_LAST = 6'(PREAMBLE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_REL
  } state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
  logic              high_half, high_half_nx;
  logic [5:0]        bit_cnt, bit_cnt_nx;
  logic              write_q, write_nx;
  logic [4:0]        phyad_q, phyad_nx;
  logic [4:0]        regad_q, regad_nx;
  logic [15:0]       wdata_q, wdata_nx;
  logic [15:0]       rx_shift, rx_shift_nx;
  logic              ta_err, ta_err_nx;

  logic              cmd_ready_nx, busy_nx, mdc_nx, mdio_o_nx, mdio_t_nx;
  logic              rsp_valid_nx, rsp_err_nx;
  logic [15:0]       rsp_rdata_nx;
  logic              start_nopre;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign start_nopre = cmd_nopre;
`else
  assign start_nopre = 1'b0;
`endif

  // Pad drive {mdio_t, mdio_o} for the bit selected by state and remaining-bit index.
  // Bit indices count down, so the index doubles as the MSB-first position in each field.
  function automatic logic [1:0] frame_drive(input state_t st, input logic [3:0] idx,
                                             input logic wr, input logic [4:0] pa,
                                             input logic [4:0] ra, input logic [15:0] wd);
    logic [13:0] hdr;
    hdr = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
    frame_drive = 2'b11;
    case (st)
      S_PRE:   frame_drive = 2'b01;
      S_HDR:   frame_drive = {1'b0, hdr[idx]};
      S_TA:    if (wr) frame_drive = {1'b0, idx[0]};
      S_DATA:  if (wr) frame_drive = {1'b0, wd[idx]};
      default: frame_drive = 2'b11;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      high_half <= 1'b0;
      bit_cnt   <= '0;
      write_q   <= 1'b0;
      phyad_q   <= '0;
      regad_q   <= '0;
      wdata_q   <= '0;
      rx_shift  <= '0;
      ta_err    <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      high_half <= high_half_nx;
      bit_cnt   <= bit_cnt_nx;
      write_q   <= write_nx;
      phyad_q   <= phyad_nx;
      regad_q   <= regad_nx;
      wdata_q   <= wdata_nx;
      rx_shift  <= rx_shift_nx;
      ta_err    <= ta_err_nx;
      cmd_ready <= cmd_ready_nx;
      busy      <= busy_nx;
      mdc       <= mdc_nx;
      mdio_o    <= mdio_o_nx;
      mdio_t    <= mdio_t_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    div_cnt_nx   = div_cnt;
    high_half_nx = high_half;
    bit_cnt_nx   = bit_cnt;
    write_nx     = write_q;
    phyad_nx     = phyad_q;
    regad_nx     = regad_q;
    wdata_nx     = wdata_q;
    rx_shift_nx  = rx_shift;
    ta_err_nx    = ta_err;
    cmd_ready_nx = cmd_ready;
    busy_nx      = busy;
    mdc_nx       = mdc;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;

    case (state)
      S_IDLE: begin
        cmd_ready_nx = 1'b1;
        busy_nx      = 1'b0;
        mdc_nx       = 1'b0;
        if (cmd_valid && cmd_ready) begin
          write_nx     = cmd_write;
          phyad_nx     = cmd_phyad;
          regad_nx     = cmd_regad;
          wdata_nx     = cmd_wdata;
          rx_shift_nx  = '0;
          ta_err_nx    = 1'b0;
          div_cnt_nx   = '0;
          high_half_nx = 1'b0;
          state_nx     = start_nopre ? S_HDR : S_PRE;
          bit_cnt_nx   = start_nopre ? 6'd13 : PRE_LAST;
          cmd_ready_nx = 1'b0;
          busy_nx      = 1'b1;
        end
      end

      default: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!high_half) begin
            // Rising MDC: the responder's bit has been stable for the whole low half.
            high_half_nx = 1'b1;
            mdc_nx       = 1'b1;
            if (!write_q && state == S_TA && bit_cnt == 6'd0) ta_err_nx = mdio_i;
            if (!write_q && state == S_DATA) rx_shift_nx = {rx_shift[14:0], mdio_i};
          end else begin
            high_half_nx = 1'b0;
            mdc_nx       = 1'b0;
            if (bit_cnt != 6'd0) begin
              bit_cnt_nx = bit_cnt - 6'd1;
            end else begin
              case (state)
                S_PRE:  begin state_nx = S_HDR;  bit_cnt_nx = 6'd13; end
                S_HDR:  begin state_nx = S_TA;   bit_cnt_nx = 6'd1;  end
                S_TA:   begin state_nx = S_DATA; bit_cnt_nx = 6'd15; end
                S_DATA: begin state_nx = S_REL;  bit_cnt_nx = 6'd0;  end
                default: begin
                  state_nx     = S_IDLE;
                  rsp_valid_nx = 1'b1;
                  rsp_rdata_nx = write_q ? 16'h0000 : rx_shift;
                  rsp_err_nx   = ~write_q & ta_err;
                end
              endcase
            end
          end
        end else begin
          div_cnt_nx = div_cnt + DIV_W'(1);
        end
      end
    endcase

    {mdio_t_nx, mdio_o_nx} = frame_drive(state_nx, bit_cnt_nx[3:0], write_nx,
                                         phyad_nx, regad_nx, wdata_nx);
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master at CLK_DIV=2: frame bitstreams, read sampling, reset and back-to-back timing.
// Define MDIO_PREAMBLE_SUPPRESS_EN to also exercise cmd_nopre.
module tb_mdio_master;
  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phyad = '0;
  logic [4:0]  cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_nopre = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_t;
  logic        mdio_i = 1'b1;

  int total = 0;
  int bad = 0;

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_BITS(32)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_phyad(cmd_phyad),
    .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_nopre(cmd_nopre),
`endif
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .mdc(mdc),
    .mdio_o(mdio_o),
    .mdio_t(mdio_t),
    .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  // Responder drive for frame bit n: TA2 low, then data MSB first, otherwise released (pulled high).
  function automatic logic resp_bit(input int n, input logic [15:0] d);
    if (n == 47) return 1'b0;
    if (n >= 48 && n <= 63) return d[63 - n];
    return 1'b1;
  endfunction

  // Runs one command; k counts cycles after the accept cycle T, sampled 1 time unit past each edge.
  task automatic run_txn(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic nopre, input logic respond,
                         input logic [15:0] rd, output int rsp_k, output logic [15:0] got_rdata,
                         output logic got_err, output int rises, output logic [64:0] o_str,
                         output logic [64:0] t_str, output logic ready_k1,
                         output logic valid_after, output logic ready_after);
    logic prev_mdc;
    rsp_k = -1; rises = 0; o_str = '0; t_str = '0;
    got_rdata = '0; got_err = 1'b0; ready_k1 = 1'b1;
    for (int w = 0; w < 10 && !cmd_ready; w++) begin
      @(posedge clk); #1;
    end
    cmd_write = wr; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd; cmd_nopre = nopre;
    cmd_valid = 1'b1;
    mdio_i = 1'b1;
    prev_mdc = mdc;
    for (int k = 1; k <= 700 && rsp_k < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ready_k1 = cmd_ready;
        cmd_valid = 1'b0;
      end
      if (mdc && !prev_mdc) begin
        o_str = {o_str[63:0], mdio_o};
        t_str = {t_str[63:0], mdio_t};
        rises++;
      end
      if (!mdc && prev_mdc && respond) mdio_i = resp_bit(rises, rd);
      prev_mdc = mdc;
      if (rsp_valid) begin
        rsp_k = k;
        got_rdata = rsp_rdata;
        got_err = rsp_err;
      end
    end
    mdio_i = 1'b1;
    cmd_nopre = 1'b0;
    @(posedge clk); #1;
    valid_after = rsp_valid;
    ready_after = cmd_ready;
  endtask

  task automatic test_reset();
    logic steady_ok;
    reset = 1'b1;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, busy, mdc, mdio_o, mdio_t, rsp_valid, rsp_err, rsp_rdata} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("[TB] FAIL reset_values got=%b_%h exp=0001100_0000",
               {cmd_ready, busy, mdc, mdio_o, mdio_t, rsp_valid, rsp_err}, rsp_rdata);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL ready_after_reset got=%b exp=10", {cmd_ready, busy});
    end
    steady_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if ({mdc, mdio_t, mdio_o, rsp_valid, cmd_ready} !== 5'b01101) steady_ok = 1'b0;
    end
    total++;
    if (steady_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_steady got=%b exp=1", steady_ok);
    end
    // Command presented in the same cycle reset is asserted must be dropped.
    cmd_write = 1'b1; cmd_phyad = 5'h07; cmd_wdata = 16'hFFFF;
    cmd_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    steady_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ({mdc, mdio_t, busy, rsp_valid} !== 4'b0100) steady_ok = 1'b0;
    end
    total++;
    if ({steady_ok, cmd_ready} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL accept_during_reset got=%b exp=11", {steady_ok, cmd_ready});
    end
  endtask

  task automatic test_write();
    int rsp_k, rises;
    logic [15:0] rdata;
    logic err, rk1, va, ra;
    logic [64:0] o_str, t_str;
    run_txn(1'b1, 5'h07, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0000,
            rsp_k, rdata, err, rises, o_str, t_str, rk1, va, ra);
    total++;
    if (rsp_k !== 261) begin bad++; $display("[TB] FAIL write_rsp_cycle got=%0d exp=261", rsp_k); end
    total++;
    if (o_str !== {32'hFFFF_FFFF, 32'b01_01_00111_00000_10_0001000101000000, 1'b1}) begin
      bad++; $display("[TB] FAIL write_bitstream got=%h exp=%h", o_str,
                      {32'hFFFF_FFFF, 32'b01_01_00111_00000_10_0001000101000000, 1'b1});
    end
    total++;
    if (t_str !== 65'h1) begin bad++; $display("[TB] FAIL write_tristate got=%h exp=1", t_str); end
    total++;
    if (rises !== 65) begin bad++; $display("[TB] FAIL write_mdc_count got=%0d exp=65", rises); end
    total++;
    if ({rdata, err} !== {16'h0000, 1'b0}) begin
      bad++; $display("[TB] FAIL write_rsp got=%h/%b exp=0000/0", rdata, err);
    end
    total++;
    if ({rk1, va, ra, mdio_t, mdio_o} !== 5'b00111) begin
      bad++; $display("[TB] FAIL write_handshake got=%b exp=00111", {rk1, va, ra, mdio_t, mdio_o});
    end
  endtask

  task automatic test_read();
    int rsp_k, rises;
    logic [15:0] rdata;
    logic err, rk1, va, ra;
    logic [64:0] o_str, t_str;
    run_txn(1'b0, 5'h07, 5'h01, 16'h0000, 1'b0, 1'b1, 16'h796D,
            rsp_k, rdata, err, rises, o_str, t_str, rk1, va, ra);
    total++;
    if (rsp_k !== 261) begin bad++; $display("[TB] FAIL read_rsp_cycle got=%0d exp=261", rsp_k); end
    total++;
    if ({rdata, err} !== {16'h796D, 1'b0}) begin
      bad++; $display("[TB] FAIL read_data got=%h/%b exp=796d/0", rdata, err);
    end
    total++;
    if (o_str[64:19] !== {32'hFFFF_FFFF, 14'b01_10_00111_00001}) begin
      bad++; $display("[TB] FAIL read_header got=%h exp=%h", o_str[64:19],
                      {32'hFFFF_FFFF, 14'b01_10_00111_00001});
    end
    total++;
    if (o_str[30:29] !== 2'b10) begin bad++; $display("[TB] FAIL read_op got=%b exp=10", o_str[30:29]); end
    total++;
    if (t_str !== {46'b0, 19'h7FFFF}) begin
      bad++; $display("[TB] FAIL read_tristate got=%h exp=%h", t_str, {46'b0, 19'h7FFFF});
    end
  endtask

  task automatic test_read_no_responder();
    int rsp_k, rises;
    logic [15:0] rdata;
    logic err, rk1, va, ra;
    logic [64:0] o_str, t_str;
    run_txn(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b0, 16'h0000,
            rsp_k, rdata, err, rises, o_str, t_str, rk1, va, ra);
    total++;
    if ({rdata, err} !== {16'hFFFF, 1'b1}) begin
      bad++; $display("[TB] FAIL noresp_data got=%h/%b exp=ffff/1", rdata, err);
    end
    total++;
    if (rsp_k !== 261) begin bad++; $display("[TB] FAIL noresp_rsp_cycle got=%0d exp=261", rsp_k); end
  endtask

  task automatic test_reset_mid();
    int rises, rsp_k;
    logic prev_mdc, reached, quiet;
    logic [15:0] rdata;
    logic err, rk1, va, ra;
    logic [64:0] o_str, t_str;
    reached = 1'b0; quiet = 1'b1; rises = 0;
    for (int w = 0; w < 10 && !cmd_ready; w++) begin
      @(posedge clk); #1;
    end
    cmd_write = 1'b1; cmd_phyad = 5'h07; cmd_regad = 5'h00; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    prev_mdc = mdc;
    for (int k = 1; k <= 400 && !reached; k++) begin
      @(posedge clk); #1;
      if (k == 1) cmd_valid = 1'b0;
      if (rsp_valid) quiet = 1'b0;
      if (mdc && !prev_mdc) rises++;
      prev_mdc = mdc;
      if (rises == 54) reached = 1'b1;
    end
    total++;
    if (reached !== 1'b1) begin bad++; $display("[TB] FAIL midreset_reach got=%0d exp=54", rises); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({mdc, mdio_t, mdio_o, cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata} !==
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("[TB] FAIL midreset_values got=%b_%h exp=0110000_0000",
               {mdc, mdio_t, mdio_o, cmd_ready, busy, rsp_valid, rsp_err}, rsp_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_ready got=%b exp=1", cmd_ready); end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || mdc) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL midreset_quiet got=%b exp=1", quiet); end
    run_txn(1'b0, 5'h11, 5'h1F, 16'h0000, 1'b0, 1'b1, 16'hA5C3,
            rsp_k, rdata, err, rises, o_str, t_str, rk1, va, ra);
    total++;
    if ({rsp_k, rdata, err} !== {32'd261, 16'hA5C3, 1'b0}) begin
      bad++; $display("[TB] FAIL midreset_followup got=%0d/%h/%b exp=261/a5c3/0", rsp_k, rdata, err);
    end
  endtask

  task automatic test_back_to_back();
    int first_rsp, second_rsp, ready_rise, t_fall, rises;
    logic prev_mdc, gap_mdc, busy_k1;
    first_rsp = -1; second_rsp = -1; ready_rise = -1; t_fall = -1; rises = 0;
    gap_mdc = 1'b0; busy_k1 = 1'b0;
    for (int w = 0; w < 10 && !cmd_ready; w++) begin
      @(posedge clk); #1;
    end
    cmd_write = 1'b1; cmd_phyad = 5'h07; cmd_regad = 5'h00; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    prev_mdc = mdc;
    for (int k = 1; k <= 700 && second_rsp < 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy_k1 = busy;
      if (mdc && !prev_mdc) rises++;
      prev_mdc = mdc;
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = k;
        else second_rsp = k;
      end
      if (first_rsp >= 0 && ready_rise < 0 && cmd_ready) ready_rise = k;
      if (ready_rise >= 0 && t_fall < 0 && !mdio_t) begin
        t_fall = k;
        cmd_valid = 1'b0;
      end
      if (first_rsp >= 0 && t_fall < 0 && mdc) gap_mdc = 1'b1;
    end
    cmd_valid = 1'b0;
    total++;
    if ({first_rsp, ready_rise, t_fall, second_rsp} !== {32'd261, 32'd262, 32'd263, 32'd523}) begin
      bad++;
      $display("[TB] FAIL b2b_timing got=%0d/%0d/%0d/%0d exp=261/262/263/523",
               first_rsp, ready_rise, t_fall, second_rsp);
    end
    total++;
    if ({busy_k1, gap_mdc} !== 2'b10) begin
      bad++; $display("[TB] FAIL b2b_busy_gap got=%b exp=10", {busy_k1, gap_mdc});
    end
    total++;
    if (rises !== 130) begin bad++; $display("[TB] FAIL b2b_mdc_count got=%0d exp=130", rises); end
  endtask

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  task automatic test_nopre();
    int rsp_k, rises;
    logic [15:0] rdata;
    logic err, rk1, va, ra;
    logic [64:0] o_str, t_str;
    run_txn(1'b1, 5'h07, 5'h00, 16'h1140, 1'b1, 1'b0, 16'h0000,
            rsp_k, rdata, err, rises, o_str, t_str, rk1, va, ra);
    total++;
    if (rsp_k !== 133) begin bad++; $display("[TB] FAIL nopre_rsp_cycle got=%0d exp=133", rsp_k); end
    total++;
    if ({rises, o_str[32:0]} !== {32'd33, 32'b01_01_00111_00000_10_0001000101000000, 1'b1}) begin
      bad++; $display("[TB] FAIL nopre_bitstream got=%0d/%h exp=33/%h", rises, o_str[32:0],
                      {32'b01_01_00111_00000_10_0001000101000000, 1'b1});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_no_responder();
    test_reset_mid();
    test_back_to_back();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    test_nopre();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
